alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle execution controller for the CPU ALU. Fetches one instruction word,
//  classifies opcode = instr[14:9] and drives the ALU active-low enable, the exec2
//  phase strobe, multiplier start, memory, stack, register-write and PC strobes.
//  Sits between the fetch/PC logic and the ALU/register file/stack/RAMd.
//  Two-phase ops: MUL/MLA/MLS, LDR, RTN. Direct memory ops (instr[15]=1) run with the ALU disabled.
// PARAMETERS
//  MUL_LATENCY  4  cycles from mul_start until mulresult is valid (>=1)
//  MEM_LATENCY  2  cycles a RAMd access occupies (>=1)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  run          in   1   leave HALT and begin fetching
//  instr        in   16  fetched instruction word
//  instr_valid  in   1   instr valid this cycle
//  jump         in   1   ALU jump-condition result
//  fetch_req    out  1   request next instruction word
//  alu_enable   out  1   ALU enable, active LOW (1 = ALU disabled, output forced 0)
//  exec2        out  1   ALU second-phase strobe
//  mul_start    out  1   1-cycle multiplier start pulse
//  mem_re       out  1   RAMd read strobe
//  mem_we       out  1   RAMd write strobe
//  stack_push   out  1   push strobe
//  stack_pop    out  1   pop strobe
//  reg_we       out  1   destination register write
//  pc_inc       out  1   PC <= PC+1
//  pc_load      out  1   PC <= ALU result (jump target)
//  halted       out  1   sequencer in HALT
//  state        out  3   current state (debug)
// BEHAVIOUR
//  - States: HALT=0, FETCH=1, EXEC=2, MULWAIT=3, MEM=4, EXEC2=5. Outputs decoded from
//    state + latched ir (+ jump in EXEC); every strobe asserts for exactly one cycle.
//  - Reset (async): state=HALT, ir=0, counter=0; halted=1, alu_enable=1, all other outputs 0.
//  - HALT: halted=1, alu_enable=1; run=1 -> FETCH. PC untouched.
//  - FETCH: fetch_req=1, alu_enable=1; on instr_valid latch ir<=instr -> EXEC; else stay.
//  - EXEC (alu_enable=0, exec2=0 unless ir[15]=1):
//    * ir[15]=1: direct memory op, alu_enable=1; ir[14]=1 mem_we else mem_re; -> MEM.
//    * JMP/JMA/JC1-JC8 (000000-001011): jump=1 -> pc_load, else pc_inc; -> FETCH.
//    * CLL 100110: stack_push + pc_load (unconditional); -> FETCH.
//    * Logic/arith/shift/MOV/MRT (001100-010110,011000-011010,011111,100000-100010,100100):
//      reg_we + pc_inc -> FETCH.
//    * MUL/MLA/MLS 011100-011110: mul_start; counter<=MUL_LATENCY-1; -> MULWAIT.
//    * PSH 101000: stack_push + pc_inc. POP 101001: stack_pop + reg_we + pc_inc. -> FETCH.
//    * LDR 101010: mem_re; -> MEM. STR 101011: mem_we; -> MEM.
//    * RTN 100111: stack_pop; -> EXEC2.
//    * STP 111111: -> HALT (no pc_inc). NOP and all undefined opcodes: pc_inc -> FETCH.
//  - MULWAIT: alu_enable=0, exec2=0; counter decrements; at 0 -> EXEC2.
//    MULWAIT lasts exactly MUL_LATENCY cycles.
//  - MEM: lasts MEM_LATENCY cycles (counter loaded MEM_LATENCY-1 on entry); at expiry:
//    LDR -> EXEC2; STR -> pc_inc, FETCH; direct load -> reg_we + pc_inc, FETCH;
//    direct store -> pc_inc, FETCH.
//    alu_enable=1 throughout direct ops, 0 for LDR/STR.
//  - EXEC2: exec2=1, alu_enable=0; MUL/MLA/MLS/LDR: reg_we + pc_inc; RTN: pc_load; -> FETCH.
//  - Counter width: $clog2(max(MUL_LATENCY,MEM_LATENCY))+1; never wraps (loaded, not free-running).
//  - pc_inc and pc_load never both high; reg_we never high outside EXEC/MEM/EXEC2.
//  - run ignored outside HALT; instr/instr_valid ignored outside FETCH.
//  - Reset mid-operation (any state) -> HALT next edge-independent; pending strobes drop at once.
// TESTING
//  1 reset then run=1, instr=ADD (op 010100) valid -> FETCH,EXEC; EXEC: reg_we=1,pc_inc=1,alu_enable=0.
//  2 MUL, MUL_LATENCY=4 -> mul_start 1 cycle, 4 MULWAIT cycles, then exec2=1+reg_we+pc_inc, back to FETCH.
//  3 JC3 with jump=1 -> pc_load=1,pc_inc=0; repeat with jump=0 -> pc_inc=1,pc_load=0.
//  4 LDR, MEM_LATENCY=2 -> mem_re in EXEC, 2 MEM cycles, EXEC2 reg_we; instr=0xC000 (store) -> alu_enable=1 throughout, mem_we.
//  5 CLL then RTN -> CLL: stack_push+pc_load; RTN: stack_pop, next cycle exec2+pc_load.
//  6 STP -> HALT, halted=1, no pc_inc; assert reset during MULWAIT -> HALT immediately, mul/exec2 strobes 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle execution controller for the CPU ALU: fetches an instruction word,
// classifies its opcode and strobes ALU, multiplier, RAMd, stack, register and PC controls.
module alu_sequencer #(
  parameter int MUL_LATENCY = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic        jump,
  output logic        fetch_req,
  output logic        alu_enable,
  output logic        exec2,
  output logic        mul_start,
  output logic        mem_re,
  output logic        mem_we,
  output logic        stack_push,
  output logic        stack_pop,
  output logic        reg_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        halted,
  output logic [2:0]  state
);

  localparam int MAX_LAT = (MUL_LATENCY > MEM_LATENCY) ? MUL_LATENCY : MEM_LATENCY;
  localparam int CW = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] MEM_LOAD = CW'(MEM_LATENCY - 1);

  localparam logic [5:0] OP_CLL = 6'b100110;
  localparam logic [5:0] OP_RTN = 6'b100111;
  localparam logic [5:0] OP_PSH = 6'b101000;
  localparam logic [5:0] OP_POP = 6'b101001;
  localparam logic [5:0] OP_LDR = 6'b101010;
  localparam logic [5:0] OP_STR = 6'b101011;
  localparam logic [5:0] OP_STP = 6'b111111;

  typedef enum logic [2:0] {
    S_HALT    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_MULWAIT = 3'd3,
    S_MEM     = 3'd4,
    S_EXEC2   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [5:0] op;
  logic       direct, is_jmp, is_reg, is_mul;

  assign op     = ir_q[14:9];
  assign direct = ir_q[15];
  assign is_jmp = (op <= 6'd11);
  assign is_mul = op inside {[6'd28:6'd30]};
  assign is_reg = op inside {[6'd12:6'd22], [6'd24:6'd26], 6'd31, [6'd32:6'd34], 6'd36};

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_HALT:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (direct || op == OP_LDR || op == OP_STR) begin
          cnt_d   = MEM_LOAD;
          state_d = S_MEM;
        end else if (is_mul) begin
          cnt_d   = MUL_LOAD;
          state_d = S_MULWAIT;
        end else if (op == OP_RTN) begin
          state_d = S_EXEC2;
        end else if (op == OP_STP) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MULWAIT: begin
        if (cnt_q == '0) state_d = S_EXEC2;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_MEM: begin
        if (cnt_q == '0) state_d = (!direct && op == OP_LDR) ? S_EXEC2 : S_FETCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_EXEC2: state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HALT;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  always_comb begin
    fetch_req  = 1'b0;
    alu_enable = 1'b0;
    exec2      = 1'b0;
    mul_start  = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    reg_we     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_HALT: begin
        halted     = 1'b1;
        alu_enable = 1'b1;
      end
      S_FETCH: begin
        fetch_req  = 1'b1;
        alu_enable = 1'b1;
      end
      S_EXEC: begin
        if (direct) begin
          alu_enable = 1'b1;
          mem_we     = ir_q[14];
          mem_re     = ~ir_q[14];
        end else if (is_jmp) begin
          pc_load = jump;
          pc_inc  = ~jump;
        end else if (op == OP_CLL) begin
          stack_push = 1'b1;
          pc_load    = 1'b1;
        end else if (is_reg) begin
          reg_we = 1'b1;
          pc_inc = 1'b1;
        end else if (is_mul) begin
          mul_start = 1'b1;
        end else if (op == OP_PSH) begin
          stack_push = 1'b1;
          pc_inc     = 1'b1;
        end else if (op == OP_POP) begin
          stack_pop = 1'b1;
          reg_we    = 1'b1;
          pc_inc    = 1'b1;
        end else if (op == OP_LDR) begin
          mem_re = 1'b1;
        end else if (op == OP_STR) begin
          mem_we = 1'b1;
        end else if (op == OP_RTN) begin
          stack_pop = 1'b1;
        end else if (op != OP_STP) begin
          pc_inc = 1'b1;
        end
      end
      S_MEM: begin
        alu_enable = direct;
        if (cnt_q == '0) begin
          if (direct) begin
            reg_we = ~ir_q[14];
            pc_inc = 1'b1;
          end else if (op == OP_STR) begin
            pc_inc = 1'b1;
          end
        end
      end
      S_EXEC2: begin
        exec2 = 1'b1;
        if (op == OP_RTN) begin
          pc_load = 1'b1;
        end else begin
          reg_we = 1'b1;
          pc_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: table of single-cycle EXEC vectors plus
// hand-written multi-cycle sequences (MUL, LDR/STR, direct memory, RTN, STP, reset).
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, instr_valid, jump;
  logic [15:0] instr;
  logic        fetch_req, alu_enable, exec2, mul_start, mem_re, mem_we;
  logic        stack_push, stack_pop, reg_we, pc_inc, pc_load, halted;
  logic [2:0]  state;

  alu_sequencer #(.MUL_LATENCY(4), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .instr_valid(instr_valid),
    .jump(jump), .fetch_req(fetch_req), .alu_enable(alu_enable), .exec2(exec2),
    .mul_start(mul_start), .mem_re(mem_re), .mem_we(mem_we), .stack_push(stack_push),
    .stack_pop(stack_pop), .reg_we(reg_we), .pc_inc(pc_inc), .pc_load(pc_load),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] FR = 12'h800, AE = 12'h400, X2 = 12'h200, MS = 12'h100;
  localparam logic [11:0] RE = 12'h080, WE = 12'h040, PU = 12'h020, PO = 12'h010;
  localparam logic [11:0] RW = 12'h008, PI = 12'h004, PL = 12'h002, HL = 12'h001;
  localparam logic [2:0] S_HALT = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2;
  localparam logic [2:0] S_MULW = 3'd3, S_MEM = 3'd4, S_EXEC2 = 3'd5;

  logic [11:0] outs;
  assign outs = {fetch_req, alu_enable, exec2, mul_start, mem_re, mem_we,
                 stack_push, stack_pop, reg_we, pc_inc, pc_load, halted};

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic        jump;
    logic [11:0] exp_outs;
    logic [2:0]  exp_next;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] opw(input int op);
    logic [5:0] o;
    o = 6'(op);
    return {1'b0, o, 9'b0};
  endfunction

  function automatic vec_t mkv(input string n, input logic [15:0] w, input logic j,
                               input logic [11:0] eo, input logic [2:0] en);
    vec_t v;
    v.name = n; v.instr = w; v.jump = j; v.exp_outs = eo; v.exp_next = en;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [2:0] es, input logic [11:0] eo);
    tests++;
    if (state !== es || outs !== eo) begin
      fails++;
      $display("FAIL %s: got state=%0d outs=%03h, expected state=%0d outs=%03h",
               nm, state, outs, es, eo);
    end else begin
      $display("[TB] ok %s state=%0d outs=%03h", nm, state, outs);
    end
  endtask

  // Present one word in FETCH; returns one cycle later with the DUT in EXEC.
  task automatic issue(input logic [15:0] w, input logic j);
    instr = w; instr_valid = 1'b1; jump = j;
    tick;
    instr_valid = 1'b0;
    instr = 16'hFFFF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mkv("ADD",        opw(20), 1'b0, RW | PI, S_FETCH);
    vecs[1]  = mkv("ADD_jump1",  opw(20), 1'b1, RW | PI, S_FETCH);
    vecs[2]  = mkv("JC3_taken",  opw(4),  1'b1, PL,      S_FETCH);
    vecs[3]  = mkv("JC3_not",    opw(4),  1'b0, PI,      S_FETCH);
    vecs[4]  = mkv("JMP_taken",  opw(0),  1'b1, PL,      S_FETCH);
    vecs[5]  = mkv("JC8_not",    opw(11), 1'b0, PI,      S_FETCH);
    vecs[6]  = mkv("CLL",        opw(38), 1'b0, PU | PL, S_FETCH);
    vecs[7]  = mkv("PSH",        opw(40), 1'b0, PU | PI, S_FETCH);
    vecs[8]  = mkv("POP",        opw(41), 1'b0, PO | RW | PI, S_FETCH);
    vecs[9]  = mkv("op12",       opw(12), 1'b0, RW | PI, S_FETCH);
    vecs[10] = mkv("op22",       opw(22), 1'b0, RW | PI, S_FETCH);
    vecs[11] = mkv("undef23",    opw(23), 1'b1, PI,      S_FETCH);
    vecs[12] = mkv("op24",       opw(24), 1'b0, RW | PI, S_FETCH);
    vecs[13] = mkv("op31",       opw(31), 1'b0, RW | PI, S_FETCH);
    vecs[14] = mkv("undef35",    opw(35), 1'b0, PI,      S_FETCH);
    vecs[15] = mkv("op36",       opw(36), 1'b0, RW | PI, S_FETCH);

    reset = 1'b1; run = 1'b0; instr = 16'h0; instr_valid = 1'b0; jump = 1'b0;
    #12;
    chk("reset", S_HALT, HL | AE);
    reset = 1'b0;
    instr_valid = 1'b1; instr = opw(20);
    tick;
    chk("halt_no_run", S_HALT, HL | AE);
    instr_valid = 1'b0;
    run = 1'b1;
    tick;
    run = 1'b0;
    chk("run_fetch", S_FETCH, FR | AE);
    run = 1'b1;
    tick;
    run = 1'b0;
    chk("fetch_wait", S_FETCH, FR | AE);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].instr, vecs[i].jump);
      chk({vecs[i].name, "_exec"}, S_EXEC, vecs[i].exp_outs);
      tick;
      chk({vecs[i].name, "_next"}, vecs[i].exp_next, FR | AE);
    end

    issue(opw(28), 1'b0);
    chk("MUL_exec", S_EXEC, MS);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("MUL_wait%0d", k), S_MULW, 12'h000);
    end
    tick;
    chk("MUL_exec2", S_EXEC2, X2 | RW | PI);
    tick;
    chk("MUL_fetch", S_FETCH, FR | AE);

    issue(opw(42), 1'b0);
    chk("LDR_exec", S_EXEC, RE);
    tick; chk("LDR_mem0", S_MEM, 12'h000);
    tick; chk("LDR_mem1", S_MEM, 12'h000);
    tick; chk("LDR_exec2", S_EXEC2, X2 | RW | PI);
    tick; chk("LDR_fetch", S_FETCH, FR | AE);

    issue(opw(43), 1'b0);
    chk("STR_exec", S_EXEC, WE);
    tick; chk("STR_mem0", S_MEM, 12'h000);
    tick; chk("STR_mem1", S_MEM, PI);
    tick; chk("STR_fetch", S_FETCH, FR | AE);

    issue(16'hC000, 1'b1);
    chk("DST_exec", S_EXEC, AE | WE);
    tick; chk("DST_mem0", S_MEM, AE);
    tick; chk("DST_mem1", S_MEM, AE | PI);
    tick; chk("DST_fetch", S_FETCH, FR | AE);

    issue(16'h8000, 1'b0);
    chk("DLD_exec", S_EXEC, AE | RE);
    tick; chk("DLD_mem0", S_MEM, AE);
    tick; chk("DLD_mem1", S_MEM, AE | RW | PI);
    tick; chk("DLD_fetch", S_FETCH, FR | AE);

    issue(opw(39), 1'b0);
    chk("RTN_exec", S_EXEC, PO);
    tick; chk("RTN_exec2", S_EXEC2, X2 | PL);
    tick; chk("RTN_fetch", S_FETCH, FR | AE);

    issue(opw(63), 1'b0);
    chk("STP_exec", S_EXEC, 12'h000);
    tick; chk("STP_halt", S_HALT, HL | AE);
    tick; chk("STP_stay", S_HALT, HL | AE);
    run = 1'b1;
    tick;
    run = 1'b0;
    chk("rerun_fetch", S_FETCH, FR | AE);

    issue(opw(29), 1'b0);
    chk("MLA_exec", S_EXEC, MS);
    tick;
    tick;
    chk("MLA_wait1", S_MULW, 12'h000);
    #2 reset = 1'b1;
    #1 chk("reset_midmul", S_HALT, HL | AE);
    tick;
    reset = 1'b0;
    tick;
    chk("post_reset", S_HALT, HL | AE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
